// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register.
// Mode encodings select the per-step operation; state_e encodes the burst controller.
package shift_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_SHL  = 3'b001;
  localparam mode_t MODE_SHR  = 3'b010;
  localparam mode_t MODE_ROL  = 3'b011;
  localparam mode_t MODE_ROR  = 3'b100;
  localparam mode_t MODE_LOAD = 3'b101;
  localparam mode_t MODE_ASR  = 3'b110;
  // 3'b111 is reserved and behaves as HOLD.

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/universal_shift_register_if.sv
// Control and data bundle for universal_shift_register.
//   enable : step qualifier          mode  : operation select
//   I      : serial fill bit         D     : parallel load data
//   start  : launch a burst          count : burst step count (0..N)
//   Q      : register contents       so    : registered shift-out bit
//   busy   : burst in progress       done  : one-cycle burst completion pulse
// master drives the controls; slave is the shift register itself.
interface universal_shift_register_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N + 1)
);
  import shift_pkg::*;

  logic          enable;
  mode_t         mode;
  logic          I;
  logic [N-1:0]  D;
  logic          start;
  logic [CW-1:0] count;
  logic [N-1:0]  Q;
  logic          so;
  logic          busy;
  logic          done;

  modport master (
    output enable, mode, I, D, start, count,
    input  Q, so, busy, done
  );

  modport slave (
    input  enable, mode, I, D, start, count,
    output Q, so, busy, done
  );

endinterface

// File: rtl/shift_step.sv
// Purely combinational single-step function of the shift register.
//   q_i, mode_i, ser_i, d_i : current contents, operation, serial fill bit, load data
//   q_o                     : contents after one step
//   so_o, so_valid_o        : bit shifted/rotated out and whether it updates so
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] q_i,
  input  mode_t        mode_i,
  input  logic         ser_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o,
  output logic         so_o,
  output logic         so_valid_o
);

  always_comb begin
    q_o        = q_i;
    so_o       = 1'b0;
    so_valid_o = 1'b0;
    case (mode_i)
      MODE_SHL: begin
        q_o        = {q_i[N-2:0], ser_i};
        so_o       = q_i[N-1];
        so_valid_o = 1'b1;
      end
      MODE_SHR: begin
        q_o        = {ser_i, q_i[N-1:1]};
        so_o       = q_i[0];
        so_valid_o = 1'b1;
      end
      MODE_ROL: begin
        q_o        = {q_i[N-2:0], q_i[N-1]};
        so_o       = q_i[N-1];
        so_valid_o = 1'b1;
      end
      MODE_ROR: begin
        q_o        = {q_i[0], q_i[N-1:1]};
        so_o       = q_i[0];
        so_valid_o = 1'b1;
      end
      MODE_ASR: begin
        q_o        = {q_i[N-1], q_i[N-1:1]};
        so_o       = q_i[0];
        so_valid_o = 1'b1;
      end
      MODE_LOAD: begin
        q_o = d_i;
      end
      default: ;  // HOLD and reserved leave Q and so untouched
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// N-bit universal shift register with an autonomous burst controller.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : slave side of universal_shift_register_if (controls in, Q/so/busy/done out)
// In IDLE each enabled clock performs one step of bus.mode. A start with a non-zero count
// latches mode and count and runs that many enabled steps in BURST, then pulses done.
module universal_shift_register
  import shift_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  universal_shift_register_if.slave    bus
);

  state_e        state_q, state_d;
  mode_t         mode_q, mode_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [N-1:0]  q_q, q_d;
  logic          so_q, so_d;
  logic          done_q, done_d;

  mode_t         step_mode;
  logic [N-1:0]  step_q;
  logic          step_so;
  logic          step_so_valid;
  logic          do_step;

  // During a burst the latched mode drives the step, never the live input.
  assign step_mode = (state_q == ST_BURST) ? mode_q : bus.mode;

  shift_step #(
    .N (N)
  ) u_shift_step (
    .q_i        (q_q),
    .mode_i     (step_mode),
    .ser_i      (bus.I),
    .d_i        (bus.D),
    .q_o        (step_q),
    .so_o       (step_so),
    .so_valid_o (step_so_valid)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    do_step     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // start wins over single-stepping and ignores enable
        if (bus.start) begin
          if (bus.count != '0) begin
            mode_d      = bus.mode;
            remaining_d = bus.count;
            state_d     = ST_BURST;
          end else begin
            done_d = 1'b1;
          end
        end else if (bus.enable) begin
          do_step = 1'b1;
        end
      end
      ST_BURST: begin
        if (bus.enable) begin
          do_step     = 1'b1;
          remaining_d = remaining_q - CW'(1);
          if (remaining_q == CW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    q_d  = q_q;
    so_d = so_q;
    if (do_step) begin
      q_d = step_q;
      if (step_so_valid) begin
        so_d = step_so;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_HOLD;
      remaining_q <= '0;
      q_q         <= '0;
      so_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      q_q         <= q_d;
      so_q        <= so_d;
      done_q      <= done_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.so   = so_q;
  assign bus.busy = (state_q == ST_BURST);
  assign bus.done = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench: each stimulus cycle pushes the hand-computed expected outputs;
// a monitor pops and compares on the falling edge.
module tb_universal_shift_register;
  import shift_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = $clog2(N + 1);

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       so;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  universal_shift_register_if #(.N(N), .CW(CW)) bus ();

  universal_shift_register #(
    .N  (N),
    .CW (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks += 4;
      if (bus.Q !== e.q) begin
        errors++;
        $display("FAIL %s Q got %h expected %h", e.name, bus.Q, e.q);
      end
      if (bus.so !== e.so) begin
        errors++;
        $display("FAIL %s so got %b expected %b", e.name, bus.so, e.so);
      end
      if (bus.busy !== e.busy) begin
        errors++;
        $display("FAIL %s busy got %b expected %b", e.name, bus.busy, e.busy);
      end
      if (bus.done !== e.done) begin
        errors++;
        $display("FAIL %s done got %b expected %b", e.name, bus.done, e.done);
      end
    end
  end

  task automatic drive(input logic en, input mode_t md, input logic si, input logic [7:0] d,
                       input logic st, input logic [CW-1:0] cnt);
    bus.enable = en;
    bus.mode   = md;
    bus.I      = si;
    bus.D      = d;
    bus.start  = st;
    bus.count  = cnt;
  endtask

  // One clock; the expected values describe outputs after this edge.
  task automatic tick(input string name, input logic [7:0] q, input logic so,
                      input logic busy, input logic done);
    exp_t e;
    @(posedge clk);
    #1;
    e.name = name;
    e.q    = q;
    e.so   = so;
    e.busy = busy;
    e.done = done;
    sb.push_back(e);
  endtask

  initial begin
    // 1. Reset with arbitrary inputs
    reset = 1'b1;
    drive(1'b1, MODE_LOAD, 1'b1, 8'h5A, 1'b1, 4'd3);
    tick("reset0", 8'h00, 1'b0, 1'b0, 1'b0);
    tick("reset1", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // 2. Load then shift, then stall
    drive(1'b1, MODE_LOAD, 1'b0, 8'hA5, 1'b0, 4'd0);
    tick("load_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    drive(1'b1, MODE_SHL, 1'b1, 8'h00, 1'b0, 4'd0);
    tick("shl", 8'h4B, 1'b1, 1'b0, 1'b0);
    drive(1'b1, MODE_SHR, 1'b0, 8'h00, 1'b0, 4'd0);
    tick("shr", 8'h25, 1'b1, 1'b0, 1'b0);
    drive(1'b0, MODE_SHL, 1'b1, 8'h00, 1'b0, 4'd0);
    for (int k = 0; k < 3; k++) tick("enable_low", 8'h25, 1'b1, 1'b0, 1'b0);

    // 3. Rotate, arithmetic shift, hold and reserved
    drive(1'b1, MODE_LOAD, 1'b0, 8'h81, 1'b0, 4'd0);
    tick("load_81a", 8'h81, 1'b1, 1'b0, 1'b0);
    drive(1'b1, MODE_ROR, 1'b0, 8'h00, 1'b0, 4'd0);
    tick("ror", 8'hC0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, MODE_LOAD, 1'b0, 8'h81, 1'b0, 4'd0);
    tick("load_81b", 8'h81, 1'b1, 1'b0, 1'b0);
    drive(1'b1, MODE_ROL, 1'b0, 8'h00, 1'b0, 4'd0);
    tick("rol", 8'h03, 1'b1, 1'b0, 1'b0);
    drive(1'b1, MODE_LOAD, 1'b0, 8'h80, 1'b0, 4'd0);
    tick("load_80", 8'h80, 1'b1, 1'b0, 1'b0);
    drive(1'b1, MODE_ASR, 1'b1, 8'h00, 1'b0, 4'd0);
    tick("asr", 8'hC0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b111, 1'b1, 8'hFF, 1'b0, 4'd0);
    tick("reserved", 8'hC0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, MODE_HOLD, 1'b1, 8'hFF, 1'b0, 4'd0);
    tick("hold", 8'hC0, 1'b0, 1'b0, 1'b0);

    // 4. Burst of 4 SHL from 0F
    drive(1'b1, MODE_LOAD, 1'b0, 8'h0F, 1'b0, 4'd0);
    tick("load_0f", 8'h0F, 1'b0, 1'b0, 1'b0);
    drive(1'b1, MODE_SHL, 1'b0, 8'h00, 1'b1, 4'd4);
    tick("burst_start", 8'h0F, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    tick("burst_s1", 8'h1E, 1'b0, 1'b1, 1'b0);
    tick("burst_s2", 8'h3C, 1'b0, 1'b1, 1'b0);
    tick("burst_s3", 8'h78, 1'b0, 1'b1, 1'b0);
    tick("burst_s4", 8'hF0, 1'b0, 1'b0, 1'b1);
    bus.enable = 1'b0;
    tick("burst_after", 8'hF0, 1'b0, 1'b0, 1'b0);

    // Same burst with a 2-cycle stall
    drive(1'b1, MODE_LOAD, 1'b0, 8'h0F, 1'b0, 4'd0);
    tick("load_0f_b", 8'h0F, 1'b0, 1'b0, 1'b0);
    drive(1'b1, MODE_SHL, 1'b0, 8'h00, 1'b1, 4'd4);
    tick("stall_start", 8'h0F, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    tick("stall_s1", 8'h1E, 1'b0, 1'b1, 1'b0);
    drive(1'b0, MODE_HOLD, 1'b0, 8'h00, 1'b0, 4'd0);
    tick("stall_a", 8'h1E, 1'b0, 1'b1, 1'b0);
    tick("stall_b", 8'h1E, 1'b0, 1'b1, 1'b0);
    bus.enable = 1'b1;
    tick("stall_s2", 8'h3C, 1'b0, 1'b1, 1'b0);
    tick("stall_s3", 8'h78, 1'b0, 1'b1, 1'b0);
    tick("stall_s4", 8'hF0, 1'b0, 1'b0, 1'b1);
    bus.enable = 1'b0;
    tick("stall_after", 8'hF0, 1'b0, 1'b0, 1'b0);

    // 5. Zero-count start
    drive(1'b1, MODE_SHL, 1'b1, 8'h00, 1'b1, 4'd0);
    tick("zero_count", 8'hF0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, MODE_SHL, 1'b1, 8'h00, 1'b0, 4'd0);
    tick("zero_after", 8'hF0, 1'b0, 1'b0, 1'b0);

    // ROL burst of 3 from 01 with mode/start toggling
    drive(1'b1, MODE_LOAD, 1'b0, 8'h01, 1'b0, 4'd0);
    tick("load_01", 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b1, MODE_ROL, 1'b0, 8'h00, 1'b1, 4'd3);
    tick("rol_start", 8'h01, 1'b0, 1'b1, 1'b0);
    drive(1'b1, MODE_SHR, 1'b1, 8'h00, 1'b1, 4'd2);
    tick("rol_s1", 8'h02, 1'b0, 1'b1, 1'b0);
    drive(1'b1, MODE_LOAD, 1'b1, 8'hFF, 1'b1, 4'd1);
    tick("rol_s2", 8'h04, 1'b0, 1'b1, 1'b0);
    drive(1'b1, MODE_ASR, 1'b1, 8'hFF, 1'b0, 4'd0);
    tick("rol_s3", 8'h08, 1'b0, 1'b0, 1'b1);
    // start while done is high is accepted
    drive(1'b1, MODE_SHR, 1'b0, 8'h00, 1'b1, 4'd1);
    tick("b2b_start", 8'h08, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    tick("b2b_s1", 8'h04, 1'b0, 1'b0, 1'b1);
    bus.enable = 1'b0;
    tick("b2b_after", 8'h04, 1'b0, 1'b0, 1'b0);

    // 6. Reset mid-burst
    drive(1'b1, MODE_LOAD, 1'b0, 8'hFF, 1'b0, 4'd0);
    tick("load_ff", 8'hFF, 1'b0, 1'b0, 1'b0);
    drive(1'b1, MODE_SHL, 1'b0, 8'h00, 1'b1, 4'd5);
    tick("rst_start", 8'hFF, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    tick("rst_s1", 8'hFE, 1'b1, 1'b1, 1'b0);
    tick("rst_s2", 8'hFC, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    tick("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(1'b1, MODE_HOLD, 1'b0, 8'h00, 1'b0, 4'd0);
    for (int k = 0; k < 5; k++) tick("rst_no_done", 8'h00, 1'b0, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised N-bit universal shift register for the RISCV_CPU datapath. It supersedes the fixed-function left/right shifter. It supports hold, logical shift, rotate, arithmetic shift and parallel load, with a registered serial output. A burst controller runs a programmed number of shift steps autonomously and reports completion with busy/done, so serialisers and multi-cycle shift units can use it without external counters.

## Interface
- N, default 8: register width (N ≥ 2).
- CW, default $clog2(N+1): width of the burst count; it can express 0..N.

- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: step qualifier; when low, all state holds.
- mode, input, 3: operation select, encoded as:
  - 000 HOLD
  - 001 SHL
  - 010 SHR
  - 011 ROL
  - 100 ROR
  - 101 LOAD
  - 110 ASR
  - 111 reserved, behaves as HOLD
- I, input, 1: serial fill bit. It enters at the LSB for SHL and at the MSB for SHR.
- D, input, N: parallel load data.
- start, input, 1: launch a burst of `count` steps of `mode`.
- count, input, CW: number of burst steps.
- Q, output, N: register contents.
- so, output, 1: registered bit shifted or rotated out on the last step.
- busy, output, 1: high while a burst is in progress.
- done, output, 1: one-cycle pulse when a burst completes.

## Operation
- Step functions, with Q' the next value of Q:
  - SHL: Q' = {Q[N-2:0], I}, so = Q[N-1].
  - SHR: Q' = {I, Q[N-1:1]}, so = Q[0].
  - ROL: Q' = {Q[N-2:0], Q[N-1]}, so = Q[N-1].
  - ROR: Q' = {Q[0], Q[N-1:1]}, so = Q[0].
  - ASR: Q' = {Q[N-1], Q[N-1:1]}, so = Q[0].
  - LOAD: Q' = D; so unchanged.
  - HOLD and reserved: no change to Q or so.
- States: IDLE and BURST.
- IDLE:
  - With enable=1 and start=0, perform one step of `mode` per clock.
  - With start=1 and count>0, latch `mode` and `count`, perform no step, and go to BURST.
  - With start=1 and count=0, perform no step, stay in IDLE, and pulse done.
  - start takes priority over single-stepping, and is honoured regardless of enable.
- BURST:
  - Each clock with enable=1 performs one step of the latched mode and decrements the remaining count.
  - enable=0 stalls the burst with no state change.
  - On the step where remaining reaches 0, return to IDLE and assert done.
  - The mode input and start are ignored throughout BURST.
- A burst with LOAD or HOLD is legal; it simply repeats that step count times.

## Timing
- On reset: Q=0, so=0, busy=0, done=0, state=IDLE, remaining=0.
- Reset mid-burst aborts the burst with no done pulse.
- Single-step latency: the step result is visible on Q and so one clock after the qualifying edge.
- Burst timeline, with start sampled at edge t and enable held high:
  - Steps occur at edges t+1 through t+count.
  - busy is high from after edge t until after edge t+count.
  - done is high for exactly the one cycle following edge t+count.
- Each cycle with enable low during a burst delays completion by one cycle.
- A zero-count start produces a done pulse in the cycle after the start edge; busy never rises.
- done is never high in the same cycle as busy.
- Back-to-back bursts:
  - A start asserted while done is high, i.e. in IDLE, is accepted normally.
  - A start asserted during BURST is dropped.

## Structure
- Package shift_pkg holds:
  - Localparams for the mode encodings (MODE_HOLD … MODE_ASR).
  - The state encoding (ST_IDLE, ST_BURST).
- Sub-module shift_step: purely combinational. It takes (Q, mode, I, D) and produces (next Q, next so, so_valid). It is parametrised by N.
- The top level holds the Q/so registers, the FSM, the latched mode and the remaining-count register.

## Test plan
All scenarios use N=8.
1. **Reset:** assert reset for 2 cycles with arbitrary inputs → Q=8'h00, so=0, busy=0, done=0.
2. **Load then shift:**
   - LOAD D=8'hA5 → Q=8'hA5.
   - SHL with I=1 → Q=8'h4B, so=1.
   - SHR with I=0 → Q=8'h25, so=1.
   - enable=0 for 3 cycles → Q stays 8'h25.
3. **Rotate and arithmetic shift:**
   - From 8'h81, ROR → Q=8'hC0, so=1.
   - From 8'h81, ROL → Q=8'h03, so=1.
   - From 8'h80, ASR → Q=8'hC0, so=0.
4. **Burst with stall:**
   - Q=8'h0F; start with count=4, mode=SHL, I=0.
   - Expected: busy high 4 cycles, Q=8'hF0, a single done pulse, so=0.
   - Repeat with enable low for 2 cycles mid-burst → busy high 6 cycles, same final Q.
5. **Zero count and ignored inputs:**
   - start with count=0 → done pulses once, busy stays 0, Q unchanged.
   - During a count=3 ROL burst from 8'h01, toggle mode and start → Q=8'h08, exactly one done pulse.
6. **Reset mid-burst:** start with count=5, SHL, from 8'hFF; assert reset after 2 steps → Q=0, busy=0, and no done pulse in any later cycle.
